// File: rtl/arm_div.sv
// arm_div: iterative restoring integer divider with a request/response handshake.
// Each divide takes WIDTH cycles. A divide by zero takes 1 cycle.
// Results are quotient, remainder and {N,Z,V,C} flags in the MAC flag order.
//
// Ports:
//   clk          rising-edge clock
//   rst_b        asynchronous active-low reset
//   div_start    request valid; accepted when div_start && div_ready
//   div_ready    high only while idle
//   div_signed   1 = two's-complement divide, 0 = unsigned
//   div_dividend dividend, sampled on the accept edge
//   div_divisor  divisor, sampled on the accept edge
//   div_flush    synchronous abort; wins over start and ack
//   div_valid    result valid, held until div_ack
//   div_ack      consumer takes the result
//   div_quot     quotient
//   div_rem      remainder
//   div_cpsr     {N,Z,V,C}
module arm_div #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             div_start,
    output logic             div_ready,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] div_dividend,
    input  logic [WIDTH-1:0] div_divisor,
    input  logic             div_flush,
    output logic             div_valid,
    input  logic             div_ack,
    output logic [WIDTH-1:0] div_quot,
    output logic [WIDTH-1:0] div_rem,
    output logic [3:0]       div_cpsr
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] q_r;        // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] r_r;        // partial remainder, always < divisor magnitude
    logic [WIDTH-1:0] dvs_mag;
    logic             sign_a, sign_b, signed_op, div0, ovf;
    logic [CW-1:0]    iter;

    logic             accept, finish;
    logic [WIDTH-1:0] dvd_mag_in, dvs_mag_in;
    logic [WIDTH:0]   shifted, diff;
    logic             ge;
    logic [WIDTH-1:0] q_next, r_next;
    logic [WIDTH-1:0] quot_res, rem_res;
    logic             v_res;

    assign div_ready = (state == IDLE);
    assign accept    = (state == IDLE) && div_start && !div_flush;

    // Negating the most-negative value wraps back to 2^(WIDTH-1).
    // Read as unsigned, that is exactly its magnitude.
    assign dvd_mag_in = (div_signed && div_dividend[WIDTH-1]) ? -div_dividend : div_dividend;
    assign dvs_mag_in = (div_signed && div_divisor[WIDTH-1])  ? -div_divisor  : div_divisor;

    always_comb begin
        shifted = {r_r, q_r[WIDTH-1]};
        diff    = shifted - {1'b0, dvs_mag};
        // With the top shifted bit set, the value already exceeds any divisor.
        // Otherwise diff[WIDTH] is the borrow of the trial subtraction.
        ge      = shifted[WIDTH] | ~diff[WIDTH];
        r_next  = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        q_next  = {q_r[WIDTH-2:0], ge};
        finish  = (state == RUN) && (div0 || (iter == CW'(WIDTH-1)));

        if (div0) begin
            quot_res = '1;
            rem_res  = q_r;       // raw dividend is latched for this case
            v_res    = 1'b1;
        end else begin
            quot_res = (signed_op && (sign_a ^ sign_b)) ? -q_next : q_next;
            rem_res  = (signed_op && sign_a) ? -r_next : r_next;
            v_res    = ovf;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (div_flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (div_start) state_nxt = RUN;
                RUN:     if (finish)    state_nxt = DONE;
                DONE:    if (div_ack)   state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            q_r       <= '0;
            r_r       <= '0;
            dvs_mag   <= '0;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            signed_op <= 1'b0;
            div0      <= 1'b0;
            ovf       <= 1'b0;
            iter      <= '0;
            div_quot  <= '0;
            div_rem   <= '0;
            div_cpsr  <= '0;
        end else if (accept) begin
            div0      <= (div_divisor == '0);
            q_r       <= (div_divisor == '0) ? div_dividend : dvd_mag_in;
            r_r       <= '0;
            dvs_mag   <= dvs_mag_in;
            sign_a    <= div_dividend[WIDTH-1];
            sign_b    <= div_divisor[WIDTH-1];
            signed_op <= div_signed;
            ovf       <= div_signed && (div_dividend == {1'b1, {(WIDTH-1){1'b0}}})
                         && (div_divisor == '1);
            iter      <= '0;
        end else if (state == RUN && !div_flush) begin
            q_r  <= q_next;
            r_r  <= r_next;
            iter <= iter + 1'b1;
            if (finish) begin
                div_quot <= quot_res;
                div_rem  <= rem_res;
                div_cpsr <= {quot_res[WIDTH-1], (quot_res == '0), v_res, 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b)                         div_valid <= 1'b0;
        else if (div_flush)                 div_valid <= 1'b0;
        else if (finish)                    div_valid <= 1'b1;
        else if (state == DONE && div_ack)  div_valid <= 1'b0;
    end

endmodule

// File: tb/tb_arm_div.sv
module tb_arm_div;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst_b = 1'b1;
    logic         div_start = 1'b0;
    logic         div_ready;
    logic         div_signed = 1'b0;
    logic [W-1:0] div_dividend = '0;
    logic [W-1:0] div_divisor = '0;
    logic         div_flush = 1'b0;
    logic         div_valid;
    logic         div_ack = 1'b0;
    logic [W-1:0] div_quot;
    logic [W-1:0] div_rem;
    logic [3:0]   div_cpsr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    arm_div #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_b        (rst_b),
        .div_start    (div_start),
        .div_ready    (div_ready),
        .div_signed   (div_signed),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_flush    (div_flush),
        .div_valid    (div_valid),
        .div_ack      (div_ack),
        .div_quot     (div_quot),
        .div_rem      (div_rem),
        .div_cpsr     (div_cpsr)
    );

    typedef struct {
        logic         sgn;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic [3:0]   f;
        int           lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on 64-bit values.
    function automatic void model(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic [3:0] f, output int lat);
        logic   v;
        longint sa, sb;
        v   = 1'b0;
        lat = W;
        if (b == 0) begin
            q = '1; r = a; v = 1'b1; lat = 1;
        end else if (sgn) begin
            sa = longint'(signed'(a));
            sb = longint'(signed'(b));
            if (sa == -64'sd2147483648 && sb == -64'sd1) begin
                q = 32'h8000_0000; r = '0; v = 1'b1;
            end else begin
                q = 32'(sa / sb);
                r = 32'(sa % sb);
            end
        end else begin
            q = a / b;
            r = a % b;
        end
        f = {q[W-1], (q == 0), v, 1'b0};
    endfunction

    task automatic issue(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        n = 0;
        while (!div_ready && n < 60) begin
            @(posedge clk); #1; n++;
        end
        if (!div_ready) check("ready_wait", 32'(div_ready), 32'd1);
        div_signed = sgn; div_dividend = a; div_divisor = b; div_start = 1'b1;
        @(posedge clk); #1;
        div_start    = 1'b0;
        div_dividend = $urandom;
        div_divisor  = $urandom;
        div_signed   = 1'($urandom);
    endtask

    task automatic run_op(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] q, output logic [W-1:0] r,
                          output logic [3:0] f, output int lat);
        issue(sgn, a, b);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (div_valid) begin
                lat = k;
                break;
            end
        end
        q = div_quot; r = div_rem; f = div_cpsr;
    endtask

    task automatic do_ack();
        div_ack = 1'b1;
        @(posedge clk); #1;
        div_ack = 1'b0;
    endtask

    initial begin
        logic [W-1:0] q, r, eq, er, q0, r0, a, b;
        logic [3:0]   f, ef, f0;
        logic         sgn, seen;
        int           lat, elat;
        logic [W-1:0] corners[5];
        longint       rm, bm;

        corners[0] = 32'h0; corners[1] = 32'h1; corners[2] = 32'hFFFF_FFFF;
        corners[3] = 32'h8000_0000; corners[4] = 32'h7FFF_FFFF;

        vecs.push_back('{0, 32'd100,        32'd7,          32'd14,         32'd2,          4'b0000, 32});
        vecs.push_back('{1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  4'b1000, 32});
        vecs.push_back('{0, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  32'd1,          4'b0000, 32});
        vecs.push_back('{0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          4'b1010, 1});
        vecs.push_back('{1, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          4'b1010, 1});
        vecs.push_back('{1, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFF9,  4'b1010, 1});
        vecs.push_back('{1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          4'b1010, 32});
        vecs.push_back('{1, 32'd3,          32'd3,          32'd1,          32'd0,          4'b0000, 32});
        vecs.push_back('{0, 32'd0,          32'd5,          32'd0,          32'd0,          4'b0100, 32});
        vecs.push_back('{0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          4'b1000, 32});
        vecs.push_back('{1, 32'h8000_0000,  32'd1,          32'h8000_0000,  32'd0,          4'b1000, 32});
        vecs.push_back('{1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          4'b1000, 32});
        vecs.push_back('{0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,          4'b0000, 32});
        vecs.push_back('{1, 32'h8000_0000,  32'd2,          32'hC000_0000,  32'd0,          4'b1000, 32});
        vecs.push_back('{1, 32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          32'hFFFF_FFFF,  4'b0100, 32});
        vecs.push_back('{0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  4'b0100, 32});

        // Reset state
        #2 rst_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(div_ready), 32'd1);
        check("rst_valid", 32'(div_valid), 32'd0);
        check("rst_quot",  div_quot, 32'd0);
        check("rst_rem",   div_rem,  32'd0);
        check("rst_cpsr",  32'(div_cpsr), 32'd0);
        rst_b = 1'b1;
        @(posedge clk); #1;

        // Directed vectors
        foreach (vecs[i]) begin
            run_op(vecs[i].sgn, vecs[i].a, vecs[i].b, q, r, f, lat);
            check($sformatf("vec%0d_lat", i),  32'(lat), 32'(vecs[i].lat));
            check($sformatf("vec%0d_quot", i), q, vecs[i].q);
            check($sformatf("vec%0d_rem", i),  r, vecs[i].r);
            check($sformatf("vec%0d_cpsr", i), 32'(f), 32'(vecs[i].f));
            do_ack();
            check($sformatf("vec%0d_ack_ready", i), {div_valid, div_ready}, 32'b01);
        end

        // Flush sampled on the 10th edge after accept
        issue(1'b0, 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        #1 div_flush = 1'b1;
        @(posedge clk); #1;
        div_flush = 1'b0;
        check("flush_ready", {div_valid, div_ready}, 32'b01);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (div_valid) seen = 1'b1;
        end
        check("flush_no_valid", 32'(seen), 32'd0);
        run_op(1'b0, 32'd3, 32'd3, q, r, f, lat);
        check("after_flush_quot", q, 32'd1);
        check("after_flush_rem",  r, 32'd0);
        do_ack();

        // Flush beats start in the same cycle
        div_start = 1'b1; div_flush = 1'b1; div_dividend = 32'd9; div_divisor = 32'd3;
        @(posedge clk); #1;
        div_start = 1'b0; div_flush = 1'b0;
        check("flush_beats_start", {div_valid, div_ready}, 32'b01);

        // Flush in DONE drops the result
        run_op(1'b0, 32'd50, 32'd5, q, r, f, lat);
        check("done_flush_q", q, 32'd10);
        div_flush = 1'b1;
        @(posedge clk); #1;
        div_flush = 1'b0;
        check("done_flush", {div_valid, div_ready}, 32'b01);

        // Asynchronous reset in the middle of a run
        issue(1'b0, 32'd1000, 32'd3);
        repeat (5) @(posedge clk);
        #1 rst_b = 1'b0;
        #1;
        check("midrst_outs", {div_quot | div_rem}, 32'd0);
        check("midrst_cpsr", 32'(div_cpsr), 32'd0);
        check("midrst_hs", {div_valid, div_ready}, 32'b01);
        @(posedge clk); #1 rst_b = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (div_valid) seen = 1'b1;
        end
        check("midrst_no_valid", 32'(seen), 32'd0);

        // Backpressure: result held, start ignored while not ready
        run_op(1'b0, 32'd100, 32'd7, q0, r0, f0, lat);
        check("bp_lat", 32'(lat), 32'd32);
        repeat (5) begin
            div_start = 1'b1; div_dividend = $urandom; div_divisor = $urandom;
            div_signed = 1'($urandom);
            @(posedge clk); #1;
            check("bp_hs", {div_valid, div_ready}, 32'b10);
            check("bp_hold", div_quot ^ 32'd14 | div_rem ^ 32'd2 | 32'(div_cpsr), 32'd0);
        end
        div_start = 1'b0;
        do_ack();
        check("bp_ack", {div_valid, div_ready}, 32'b01);
        repeat (3) @(posedge clk);
        #1 check("bp_no_queue", {div_valid, div_ready}, 32'b01);

        // Random sweep against the arithmetic model
        for (int n = 0; n < 200; n++) begin
            sgn = 1'($urandom);
            a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
            case ($urandom_range(0, 3))
                0:       b = corners[$urandom_range(0, 4)];
                1:       b = $urandom_range(1, 20);
                default: b = $urandom;
            endcase
            model(sgn, a, b, eq, er, ef, elat);
            run_op(sgn, a, b, q, r, f, lat);
            check($sformatf("rnd%0d_lat", n),  32'(lat), 32'(elat));
            check($sformatf("rnd%0d_quot", n), q, eq);
            check($sformatf("rnd%0d_rem", n),  r, er);
            check($sformatf("rnd%0d_cpsr", n), 32'(f), 32'(ef));
            if (b != 0) begin
                check($sformatf("rnd%0d_inv", n), q * b + r, a);
                rm = sgn ? longint'(signed'(r)) : longint'(r);
                bm = sgn ? longint'(signed'(b)) : longint'(b);
                if (rm < 0) rm = -rm;
                if (bm < 0) bm = -bm;
                check($sformatf("rnd%0d_rem_mag", n), 32'(rm < bm), 32'd1);
            end
            do_ack();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
